// File: rtl/alu_mdu_control_if.sv
// Execute-stage bundle shared by the ALU decode and the M-extension unit.
// The pipeline side drives the request fields (master); alu_mdu_control
// consumes them and returns decode, handshake and result signals (slave).
interface alu_mdu_control_if #(
    parameter int XLEN = 32
);
    logic [1:0]      alu_op_type;
    logic [2:0]      inst_funct3;
    logic [6:0]      inst_funct7;
    logic            req_valid;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      alu_function;
    logic            is_mext;
    logic            req_ready;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            stall;

    modport master (
        output alu_op_type, inst_funct3, inst_funct7, req_valid, rs1, rs2,
        input  alu_function, is_mext, req_ready, resp_valid, resp_data, stall
    );

    modport slave (
        input  alu_op_type, inst_funct3, inst_funct7, req_valid, rs1, rs2,
        output alu_function, is_mext, req_ready, resp_valid, resp_data, stall
    );
endinterface

// File: rtl/alu_mdu_control.sv
// ALU function decode plus an iterative RV32M multiply/divide unit.
// Multiply is a shift-add over XLEN cycles, divide is restoring division
// over XLEN cycles; both run on operand magnitudes and fix the sign at the
// end. Optional macro MDU_FAST_PATH_EN: divide-by-zero and signed overflow
// complete straight from acceptance instead of iterating.
module alu_mdu_control #(
    parameter int XLEN = 32
) (
    input logic              clock,
    input logic              reset_n,
    alu_mdu_control_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] CTL_ALU_ADD    = 2'd0;
    localparam logic [1:0] CTL_ALU_OP     = 2'd1;
    localparam logic [1:0] CTL_ALU_OP_IMM = 2'd2;
    localparam logic [1:0] CTL_ALU_BRANCH = 2'd3;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_SEQ  = 5'd10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d;          // multiplicand magnitude
    logic [XLEN-1:0]   b_q, b_d;          // divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
    logic              neg_q, neg_d;      // product / quotient is negative
    logic              rneg_q, rneg_d;    // remainder is negative (dividend sign)
    logic              div0_q, div0_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;

    logic            is_mext;
    logic [4:0]      base_fn;
    logic [4:0]      alu_fn;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_top;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_res;
    logic              last_step;

    assign is_mext = (bus.alu_op_type == CTL_ALU_OP) && (bus.inst_funct7 == 7'b0000001);

    assign bus.is_mext      = is_mext;
    assign bus.alu_function = alu_fn;
    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.stall        = bus.req_valid && is_mext && !resp_valid_q;

    // Base ALU function decode; undefined encodings are left as don't-care
    always_comb begin
        case (bus.inst_funct3)
            3'b000:  base_fn = ALU_ADD;
            3'b001:  base_fn = ALU_SLL;
            3'b010:  base_fn = ALU_SLT;
            3'b011:  base_fn = ALU_SLTU;
            3'b100:  base_fn = ALU_XOR;
            3'b101:  base_fn = ALU_SRL;
            3'b110:  base_fn = ALU_OR;
            default: base_fn = ALU_AND;
        endcase
        alu_fn = 5'bx;
        case (bus.alu_op_type)
            CTL_ALU_ADD: alu_fn = ALU_ADD;
            CTL_ALU_OP: begin
                if (!bus.inst_funct7[5])            alu_fn = base_fn;
                else if (bus.inst_funct3 == 3'b000) alu_fn = ALU_SUB;
                else if (bus.inst_funct3 == 3'b101) alu_fn = ALU_SRA;
            end
            CTL_ALU_OP_IMM: begin
                // Immediate forms have no SUB; only shifts carry a secondary op
                if (bus.inst_funct7[5] && bus.inst_funct3[1:0] == 2'b01) begin
                    if (bus.inst_funct3[2]) alu_fn = ALU_SRA;
                end else begin
                    alu_fn = base_fn;
                end
            end
            default: begin
                case (bus.inst_funct3)
                    3'b000, 3'b001: alu_fn = ALU_SEQ;
                    3'b100, 3'b101: alu_fn = ALU_SLT;
                    3'b110, 3'b111: alu_fn = ALU_SLTU;
                    default:        alu_fn = 5'bx;
                endcase
            end
        endcase
    end

    // Operand signedness per funct3 and conversion to magnitudes at acceptance
    always_comb begin
        a_sgn = (bus.inst_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110})
                && bus.rs1[XLEN-1];
        b_sgn = (bus.inst_funct3 inside {3'b000, 3'b001, 3'b100, 3'b110})
                && bus.rs2[XLEN-1];
        a_mag = a_sgn ? -bus.rs1 : bus.rs1;
        b_mag = b_sgn ? -bus.rs2 : bus.rs2;
    end

    // One datapath step (shift-add or restoring divide) and the final sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, b_q};
        div_next = div_diff[XLEN] ? {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        div_quo  = div_next[XLEN-1:0];
        div_rem  = div_next[2*XLEN-1:XLEN];
        // Divide-by-zero leaves the dividend in the remainder already; only
        // the quotient needs overriding. Signed overflow falls out naturally.
        div_res  = f3_q[1] ? (rneg_q ? -div_rem : div_rem)
                           : (div0_q ? '1 : (neg_q ? -div_quo : div_quo));
        last_step = (cnt_q == CW'(XLEN - 1));
    end

    // Next-state logic for the MDU sequencer and its datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        neg_d        = neg_q;
        rneg_d       = rneg_q;
        div0_d       = div0_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && is_mext) begin
                    f3_d   = bus.inst_funct3;
                    a_d    = a_mag;
                    b_d    = b_mag;
                    neg_d  = a_sgn ^ b_sgn;
                    rneg_d = a_sgn;
                    div0_d = (bus.rs2 == '0);
                    cnt_d  = '0;
                    acc_d  = bus.inst_funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                    state_d = bus.inst_funct3[2] ? S_DIV : S_MUL;
`ifdef MDU_FAST_PATH_EN
                    if (bus.inst_funct3[2]) begin
                        if (bus.rs2 == '0) begin
                            state_d      = S_DONE;
                            resp_valid_d = 1'b1;
                            resp_data_d  = bus.inst_funct3[1] ? bus.rs1 : '1;
                        end else if (!bus.inst_funct3[0] && bus.rs2 == '1 &&
                                     bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) begin
                            state_d      = S_DONE;
                            resp_valid_d = 1'b1;
                            resp_data_d  = bus.inst_funct3[1] ? '0 : bus.rs1;
                        end
                    end
`endif
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = mul_res;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = div_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            rneg_q       <= 1'b0;
            div0_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            neg_q        <= neg_d;
            rneg_q       <= rneg_d;
            div0_q       <= div0_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end
endmodule

// File: doc/alu_mdu_control.md
ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width (16..64, even).
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port alu_op_type, input, 2: CTL_ALU_ADD / CTL_ALU_OP / CTL_ALU_OP_IMM / CTL_ALU_BRANCH.
REQ-005 SHALL have port inst_funct3, input, 3: instruction funct3.
REQ-006 SHALL have port inst_funct7, input, 7: instruction funct7.
REQ-007 SHALL have port req_valid, input, 1: instruction in execute is valid.
REQ-008 SHALL have ports rs1 and rs2, input, XLEN each: source operands.
REQ-009 SHALL have port alu_function, output, 5: ALU_* code for base ops, combinational.
REQ-010 SHALL have port is_mext, output, 1: current instruction is RV32M, combinational.
REQ-011 SHALL have port req_ready, output, 1: MDU can accept (state IDLE).
REQ-012 SHALL have port resp_valid, output, 1: one-cycle pulse, resp_data valid.
REQ-013 SHALL have port resp_data, output, XLEN: M-extension result.
REQ-014 SHALL have port stall, output, 1: pipeline hold request.

Function
REQ-015 SHALL decode is_mext = (alu_op_type==CTL_ALU_OP) && (inst_funct7==7'b0000001).
REQ-016 SHALL decode alu_function per rv_constants:
- CTL_ALU_ADD gives ALU_ADD.
- CTL_ALU_OP gives the funct3 default op; funct7[5]=1 selects SUB (funct3 000) or SRA (funct3 101).
- CTL_ALU_OP_IMM uses the secondary op only when funct7[5]=1 and funct3[1:0]=01.
- CTL_ALU_BRANCH: EQ/NE give SEQ, LT/GE give SLT, LTU/GEU give SLTU.
- Undefined combinations give 'x.
REQ-017 SHALL implement FSM states IDLE, MUL, DIV, DONE; req_ready = (state==IDLE).
REQ-018 SHALL accept when req_valid && is_mext && req_ready at a rising edge:
- Latch funct3 and operand magnitudes/signs.
- Enter MUL for funct3 0xx, DIV for 1xx.
REQ-019 SHALL in MUL perform one shift-add step per cycle for XLEN cycles, then enter DONE.
REQ-020 SHALL in DIV perform one restoring-division step per cycle for XLEN cycles, then enter DONE.
REQ-021 SHALL assert resp_valid only in DONE (exactly one cycle), then return to IDLE; normal latency: resp_valid high XLEN+1 cycles after the acceptance edge.
REQ-022 SHALL compute results per RISC-V M:
- MUL: low XLEN bits.
- MULH: s*s high. MULHSU: s*u high. MULHU: u*u high.
- DIV/REM: signed, truncating toward zero; remainder takes the dividend's sign.
- DIVU/REMU: unsigned.
- Products use a 2*XLEN internal width.
REQ-023 SHALL return for divide-by-zero: quotient all ones, remainder = rs1.
REQ-024 SHALL return for signed overflow (rs1=most-negative, rs2=-1): quotient = rs1, remainder = 0.
REQ-025 SHALL drive stall = req_valid && is_mext && !resp_valid.
REQ-026 SHALL ignore req_valid while not IDLE; latched operands SHALL NOT change mid-operation.
REQ-027 SHALL hold resp_data stable from DONE until the next acceptance.
REQ-028 SHALL allow back-to-back operation: a request presented in the cycle after DONE (state IDLE) is accepted.

Reset
REQ-029 SHALL on reset_n=0 at a rising edge force state IDLE, resp_valid 0, resp_data 0, and clear iteration counter and datapath registers.
REQ-030 SHALL abort any in-flight operation on reset with no resp_valid pulse; req_ready=1 in the first cycle after reset release.

Configuration
REQ-031 SHALL support macro MDU_FAST_PATH_EN:
- Defined: divide-by-zero and signed overflow go directly to DONE at acceptance, so resp_valid is high 1 cycle after the acceptance edge.
- Undefined: every M op takes XLEN+1 cycles; results are identical to REQ-023/024.

Verification (XLEN=32)
REQ-032 SHALL cover: MUL rs1=7, rs2=0xFFFFFFFD -> resp_data 0xFFFFFFEB, resp_valid 33 cycles after accept, stall high until then.
REQ-033 SHALL cover: MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU same operands -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-035 SHALL cover: DIVU rs1=5, rs2=0 -> 0xFFFFFFFF; REMU -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; latency 1 with MDU_FAST_PATH_EN, 33 without.
REQ-036 SHALL cover: reset_n low at cycle 10 of a DIV -> no resp_valid pulse, req_ready=1 after release, next MUL 3*4 -> 12.
REQ-037 SHALL cover: alu_op_type=CTL_ALU_OP, funct3=000, funct7=0100000 -> alu_function=ALU_SUB, is_mext=0, stall=0; funct7=0000001 -> is_mext=1, stall=1.
